// File: rtl/systolic_ctrl.sv
// Tile sequencer for an ARRAY_N x ARRAY_N systolic MAC grid: skewed operand indices, clear, drain, done.
// Optional K-split accumulation (accum_i suppresses the clear) is enabled by SYSTOLIC_CTRL_ACCUM_EN.
module systolic_ctrl #(
  parameter int unsigned ARRAY_N   = 4,
  parameter int unsigned K_WIDTH   = 8,
  parameter int unsigned CNT_WIDTH = 10
) (
  input  logic                       clk_i,
  input  logic                       rst_ni,
  input  logic                       start_i,
  input  logic [K_WIDTH-1:0]         k_len_i,
`ifdef SYSTOLIC_CTRL_ACCUM_EN
  input  logic                       accum_i,
`endif
  input  logic                       done_ack_i,
  output logic                       ready_o,
  output logic [ARRAY_N-1:0]         lane_valid_o,
  output logic [ARRAY_N*K_WIDTH-1:0] lane_idx_o,
  output logic                       clear_o,
  output logic                       busy_o,
  output logic                       done_o
);

  localparam logic [1:0] StIdle  = 2'd0;
  localparam logic [1:0] StFeed  = 2'd1;
  localparam logic [1:0] StDrain = 2'd2;
  localparam logic [1:0] StDone  = 2'd3;

  localparam logic [CNT_WIDTH-1:0] FeedTail  = CNT_WIDTH'(ARRAY_N - 2);
  localparam logic [CNT_WIDTH-1:0] DrainTail = CNT_WIDTH'(2 * ARRAY_N - 2);

  logic [1:0]           state_q, state_d;
  logic [CNT_WIDTH-1:0] cnt_q, cnt_d;
  logic [K_WIDTH-1:0]   k_len_q, k_len_d;
  logic [CNT_WIDTH-1:0] k_ext;
  logic [CNT_WIDTH-1:0] feed_last;
  logic [CNT_WIDTH-1:0] drain_last;
  logic                 accept;
  logic                 in_feed;
  logic                 clear_en;

  assign k_ext      = CNT_WIDTH'(k_len_q);
  assign feed_last  = k_ext + FeedTail;
  assign drain_last = k_ext + DrainTail;
  assign accept     = start_i && (state_q == StIdle) && (k_len_i != '0);
  assign in_feed    = (state_q == StFeed);

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    k_len_d = k_len_q;
    case (state_q)
      StIdle: begin
        if (accept) begin
          state_d = StFeed;
          cnt_d   = '0;
          k_len_d = k_len_i;
        end
      end
      StFeed: begin
        cnt_d = cnt_q + 1'b1;
        if (cnt_q == feed_last) begin
          state_d = StDrain;
        end
      end
      StDrain: begin
        cnt_d = cnt_q + 1'b1;
        if (cnt_q == drain_last) begin
          state_d = StDone;
        end
      end
      StDone: begin
        if (done_ack_i) begin
          state_d = StIdle;
          cnt_d   = '0;
        end
      end
      default: begin
        state_d = StIdle;
        cnt_d   = '0;
      end
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= StIdle;
      cnt_q   <= '0;
      k_len_q <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      k_len_q <= k_len_d;
    end
  end

`ifdef SYSTOLIC_CTRL_ACCUM_EN
  logic accum_q;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      accum_q <= 1'b0;
    end else if (accept) begin
      accum_q <= accum_i;
    end
  end

  assign clear_en = !accum_q;
`else
  assign clear_en = 1'b1;
`endif

  // Lane r reads index t-r while 0 <= t-r < k_len; the skew lines operands up at each PE.
  for (genvar r = 0; r < ARRAY_N; r++) begin : g_lane
    localparam logic [CNT_WIDTH-1:0] LaneOff = CNT_WIDTH'(r);
    logic [CNT_WIDTH-1:0] lane_t;
    logic                 lane_on;

    assign lane_t          = cnt_q - LaneOff;
    assign lane_on         = in_feed && (cnt_q >= LaneOff) && (lane_t < k_ext);
    assign lane_valid_o[r] = lane_on;
    assign lane_idx_o[r*K_WIDTH +: K_WIDTH] = lane_on ? K_WIDTH'(lane_t) : '0;
  end

  assign clear_o = in_feed && (cnt_q == '0) && clear_en;
  assign ready_o = (state_q == StIdle);
  assign busy_o  = (state_q == StFeed) || (state_q == StDrain);
  assign done_o  = (state_q == StDone);

endmodule

// File: doc/systolic_ctrl.md
Name: systolic_ctrl

Overview:
- Sequencer for an ARRAY_N x ARRAY_N systolic grid of mac PEs computing one output tile C = A x B, with inner dimension k_len.
- Accepts a tile command and emits skewed per-lane operand-buffer read indices and lane-valid strobes. A-row r and B-column c share lane timing.
- Pulses the accumulator clear into the array corner, waits out the array pipeline, then flags results stable until the consumer acknowledges readout.

Parameters:
- ARRAY_N, 4, rows/columns of the PE grid (>=2).
- K_WIDTH, 8, width of k_len and of each lane index; max k_len = 2^K_WIDTH-1.
- CNT_WIDTH, 10, width of internal cycle counter; must hold K_MAX+2*ARRAY_N.

Ports:
- clk_i  in  1  clock.
- rst_ni  in  1  reset, asynchronous, active-low.
- start_i  in  1  tile request; accepted when start_i && ready_o && k_len_i!=0.
- k_len_i  in  K_WIDTH  inner dimension, sampled on acceptance.
- ready_o  out  1  high only in IDLE.
- lane_valid_o  out  ARRAY_N  bit r: lane r (A row r / B col r) carries a real operand this cycle. Feeder drives 0 into the array when low.
- lane_idx_o  out  ARRAY_N*K_WIDTH  slice r = k index read for lane r (t-r); 0 when lane invalid.
- clear_o  out  1  clear pulse into PE(0,0) clear_i; the array propagates it with the same skew as the data.
- busy_o  out  1  high in FEED and DRAIN.
- done_o  out  1  high in DONE: every psum_o in the array is final.
- done_ack_i  in  1  consumer has read results; releases DONE.

Behaviour:
- States: IDLE, FEED, DRAIN, DONE. Reset: IDLE, counter 0, k_len register 0. All outputs 0 except ready_o=1.
- IDLE -> FEED on acceptance. Latch k_len_i and clear the counter t. Cycle 0 is the first FEED cycle, i.e. the cycle after acceptance.
- start_i with k_len_i==0 is ignored: no state change, ready_o stays 1.
- FEED occupies cycles t=0..k_len+ARRAY_N-2.
  - lane_valid_o[r] = (t>=r) && (t<r+k_len).
  - lane_idx_o slice r = t-r when valid, else 0.
  - clear_o = 1 only at t=0, coincident with lane 0 index 0. This clear reaches PE(i,j) together with its first operand pair.
- FEED -> DRAIN after t=k_len+ARRAY_N-2.
- DRAIN lasts exactly ARRAY_N cycles with all lanes invalid. This covers ARRAY_N-1 hops plus the 2-cycle src-to-psum latency of the last PE.
- DRAIN -> DONE. done_o rises at cycle k_len+2*ARRAY_N-1. PE(ARRAY_N-1,ARRAY_N-1) psum_o is final from that cycle.
- DONE holds done_o=1 and ignores start_i until done_ack_i=1. done_ack_i is sampled in DONE only, then -> IDLE. ready_o=1 the next cycle.
- done_ack_i outside DONE has no effect.
- Back-to-back: earliest next acceptance is the cycle after leaving DONE. The new tile's clear_o discards the old psums.
- Counter compares use k_len zero-extended to CNT_WIDTH. No wrap occurs within the allowed range.
- rst_ni low at any time (including mid-FEED): immediate return to reset values. clear_o, lane_valid_o and done_o drop asynchronously.
- Outputs are registered or decoded from state/counter only. There is no combinational path from start_i to lane outputs.

Optional Feature:
- Macro SYSTOLIC_CTRL_ACCUM_EN.
- Defined: adds input port accum_i (1 bit), sampled on acceptance. If accum_i=1, clear_o stays 0 for that tile, so the array adds the new products onto the existing psums (K-split accumulation). Sequencing is otherwise identical.
- Undefined: no accum_i port; clear_o always pulses at t=0.

Test Plan:
- ARRAY_N=4, k_len=3, start at cycle -1 -> lane_valid_o[0] high cycles 0-2 and [3] high cycles 3-5. lane_idx_o slice 2 = 0,1,2 at cycles 2,3,4. clear_o only at cycle 0. done_o first high at cycle 10.
- Full compute with PE array (A=B=identity scaled 1.0 = 0x0100, k_len=4) -> at done_o every diagonal psum_o = 0x0100 and off-diagonal = 0. Second tile gives a fresh result, not accumulated.
- start_i with k_len_i=0 -> ready_o stays 1, busy_o stays 0, no lane activity for 20 cycles.
- done_o held 5 cycles with start_i high throughout -> no acceptance. done_ack_i at cycle +5 -> IDLE next cycle, then acceptance on the following cycle.
- rst_ni pulsed low at FEED t=2 -> lane_valid_o=0, clear_o=0, ready_o=1 immediately. A new start runs a full correct tile.
- SYSTOLIC_CTRL_ACCUM_EN, two tiles k_len=2 each, second with accum_i=1 -> no clear on the second tile. Final psums equal the k_len=4 single-tile result.
